// File: rtl/versat_native_initiator_if.sv
// versat_native_initiator_if: command, write/read streams, status and native port of the initiator
interface versat_native_initiator_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              done;
    logic              error;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, ready, rdata,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, error, valid, addr, wstrb, wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, ready, rdata,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, error, valid, addr, wstrb, wdata
    );
endinterface

// File: rtl/versat_native_initiator.sv
// versat_native_initiator: burst initiator issuing one native transaction per word; VERSAT_INIT_TIMEOUT_EN adds a REQ timeout
module versat_native_initiator #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
`ifdef VERSAT_INIT_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input logic clk,
    input logic rst,
    versat_native_initiator_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, REQ, DRAIN, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              last;

`ifdef VERSAT_INIT_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          error_q, error_d;
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign last          = rem_q == LEN_W'(1);
    assign bus.cmd_ready = state_q == IDLE;
    assign bus.wr_ready  = state_q == FETCH;
    assign bus.valid     = state_q == REQ;
    assign bus.rd_valid  = state_q == DRAIN;
    assign bus.done      = state_q == FIN;
    assign bus.busy      = state_q != IDLE;
    assign bus.addr      = addr_q;
    assign bus.wstrb     = {(DATA_W/8){write_q}};
    assign bus.wdata     = wdata_q;
    assign bus.rd_data   = rd_data_q;

    // State register; reset abandons any partial burst without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rd_data_q <= '0;
`ifdef VERSAT_INIT_TIMEOUT_EN
            tmo_q     <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
`ifdef VERSAT_INIT_TIMEOUT_EN
            tmo_q     <= tmo_d;
            error_q   <= error_d;
`endif
        end
    end

    // Next-state: one word per FETCH/REQ (write) or REQ/DRAIN (read) pair
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
`ifdef VERSAT_INIT_TIMEOUT_EN
        tmo_d     = '0;
        error_d   = error_q;
`endif
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                addr_d  = bus.cmd_addr;
                rem_d   = bus.cmd_len;
                write_d = bus.cmd_write;
`ifdef VERSAT_INIT_TIMEOUT_EN
                error_d = 1'b0;
`endif
                state_d = (bus.cmd_len == '0) ? FIN : bus.cmd_write ? FETCH : REQ;
            end
            FETCH: if (bus.wr_valid) begin
                wdata_d = bus.wr_data;
                state_d = REQ;
            end
            REQ: if (bus.ready) begin
                if (!write_q) begin
                    rd_data_d = bus.rdata;
                    state_d   = DRAIN;
                end else begin
                    rem_d   = rem_q - 1'b1;
                    addr_d  = last ? addr_q : addr_q + 1'b1;
                    state_d = last ? FIN : FETCH;
                end
            end
`ifdef VERSAT_INIT_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
                error_d = 1'b1;
                state_d = FIN;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
`endif
            DRAIN: if (bus.rd_ready) begin
                rem_d   = rem_q - 1'b1;
                addr_d  = last ? addr_q : addr_q + 1'b1;
                state_d = last ? FIN : REQ;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_versat_native_initiator.sv
// tb_versat_native_initiator: directed checks of write/read bursts, empty burst, wrap, reset abort and REQ wait
module tb_versat_native_initiator;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;

    versat_native_initiator_if #(.ADDR_W(11), .DATA_W(32), .LEN_W(11)) bus ();

`ifdef VERSAT_INIT_TIMEOUT_EN
    versat_native_initiator #(.ADDR_W(11), .DATA_W(32), .LEN_W(11), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
`else
    versat_native_initiator #(.ADDR_W(11), .DATA_W(32), .LEN_W(11)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
`endif

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic wr, input logic [10:0] a, input logic [10:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        logic hs;
        int   k;
        int   dn;
        int   lows;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0; bus.ready = 1'b0; bus.rdata = '0;
        tick();
        tick();
        chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk1("rst_valid", bus.valid, 1'b0);
        chk1("rst_wr_ready", bus.wr_ready, 1'b0);
        chk1("rst_rd_valid", bus.rd_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_error", bus.error, 1'b0);
        chk32("rst_addr", 32'(bus.addr), 32'h0);
        chk32("rst_wstrb", 32'(bus.wstrb), 32'h0);
        chk32("rst_wdata", bus.wdata, 32'h0);
        chk32("rst_rd_data", bus.rd_data, 32'h0);
        rst = 1'b0;
        tick();

        // write burst of 4 with zero-wait slave
        bus.ready = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data = 32'hA0;
        accept(1'b1, 11'h400, 11'd4);
        k = 0;
        dn = 0;
        repeat (20) begin
            if (bus.valid) begin
                chk32("w_addr", 32'(bus.addr), 32'h400 + 32'(k));
                chk32("w_wstrb", 32'(bus.wstrb), 32'hF);
                chk32("w_wdata", bus.wdata, 32'hA0 + 32'(k));
                k++;
            end
            if (bus.done) dn++;
            hs = bus.wr_ready;
            tick();
            if (hs) bus.wr_data = bus.wr_data + 1;
        end
        chk32("w_requests", 32'(k), 32'd4);
        chk32("w_done_pulses", 32'(dn), 32'd1);
        bus.ready = 1'b0;
        bus.wr_valid = 1'b0;

        // read burst of 2: slave waits, consumer stalls
        accept(1'b0, 11'h010, 11'd2);
        chk1("r_valid1", bus.valid, 1'b1);
        chk32("r_addr1", 32'(bus.addr), 32'h010);
        chk32("r_wstrb", 32'(bus.wstrb), 32'h0);
        chk1("r_busy", bus.busy, 1'b1);
        tick();
        chk1("r_valid2", bus.valid, 1'b1);
        chk32("r_addr2", 32'(bus.addr), 32'h010);
        tick();
        chk1("r_valid3", bus.valid, 1'b1);
        chk32("r_addr3", 32'(bus.addr), 32'h010);
        bus.ready = 1'b1;
        bus.rdata = 32'hC0DE0010;
        tick();
        bus.ready = 1'b0;
        bus.rdata = 32'h0;
        repeat (5) begin
            chk1("r_drain_valid", bus.valid, 1'b0);
            chk1("r_drain_rd_valid", bus.rd_valid, 1'b1);
            chk32("r_drain_data", bus.rd_data, 32'hC0DE0010);
            tick();
        end
        chk1("r_stall_no_req", bus.valid, 1'b0);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk1("r_valid_w2", bus.valid, 1'b1);
        chk32("r_addr_w2", 32'(bus.addr), 32'h011);
        chk1("r_rd_valid_w2", bus.rd_valid, 1'b0);
        bus.ready = 1'b1;
        bus.rdata = 32'hC0DE0011;
        tick();
        bus.ready = 1'b0;
        chk1("r_rd_valid2", bus.rd_valid, 1'b1);
        chk32("r_data2", bus.rd_data, 32'hC0DE0011);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk1("r_done", bus.done, 1'b1);
        tick();
        chk1("r_done_end", bus.done, 1'b0);
        chk1("r_idle_cmd_ready", bus.cmd_ready, 1'b1);

        // empty burst
        accept(1'b1, 11'h123, 11'd0);
        chk1("e_done", bus.done, 1'b1);
        chk1("e_valid", bus.valid, 1'b0);
        chk1("e_wr_ready", bus.wr_ready, 1'b0);
        chk1("e_cmd_ready_fin", bus.cmd_ready, 1'b0);
        tick();
        chk1("e_cmd_ready", bus.cmd_ready, 1'b1);
        chk1("e_done_end", bus.done, 1'b0);

        // read across the address wrap with handshakes held high
        bus.ready = 1'b1;
        bus.rd_ready = 1'b1;
        bus.rdata = 32'h55;
        tick();
        chk1("x_idle_no_rd_valid", bus.rd_valid, 1'b0);
        accept(1'b0, 11'h7FF, 11'd2);
        chk1("x_valid1", bus.valid, 1'b1);
        chk32("x_addr1", 32'(bus.addr), 32'h7FF);
        chk32("x_wstrb1", 32'(bus.wstrb), 32'h0);
        tick();
        chk1("x_rd_valid1", bus.rd_valid, 1'b1);
        chk32("x_rd_data1", bus.rd_data, 32'h55);
        tick();
        chk1("x_valid2", bus.valid, 1'b1);
        chk32("x_addr2", 32'(bus.addr), 32'h000);
        chk32("x_wstrb2", 32'(bus.wstrb), 32'h0);
        tick();
        chk1("x_rd_valid2", bus.rd_valid, 1'b1);
        tick();
        chk1("x_done", bus.done, 1'b1);
        tick();
        chk1("x_cmd_ready", bus.cmd_ready, 1'b1);
        bus.ready = 1'b0;
        bus.rd_ready = 1'b0;

        // reset in the middle of a write burst
        bus.ready = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data = 32'h11;
        accept(1'b1, 11'h100, 11'd4);
        tick();
        chk32("a_addr1", 32'(bus.addr), 32'h100);
        tick();
        tick();
        chk32("a_addr2", 32'(bus.addr), 32'h101);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("a_valid", bus.valid, 1'b0);
        chk1("a_busy", bus.busy, 1'b0);
        chk1("a_cmd_ready", bus.cmd_ready, 1'b1);
        chk1("a_wr_ready", bus.wr_ready, 1'b0);
        chk1("a_done", bus.done, 1'b0);
        chk32("a_addr", 32'(bus.addr), 32'h0);
        chk32("a_wdata", bus.wdata, 32'h0);
        tick();
        chk1("a_done_after", bus.done, 1'b0);
        bus.wr_data = 32'hBEEF;
        accept(1'b1, 11'h200, 11'd1);
        chk1("a2_wr_ready", bus.wr_ready, 1'b1);
        tick();
        chk1("a2_valid", bus.valid, 1'b1);
        chk32("a2_addr", 32'(bus.addr), 32'h200);
        chk32("a2_wdata", bus.wdata, 32'hBEEF);
        chk32("a2_wstrb", 32'(bus.wstrb), 32'hF);
        tick();
        chk1("a2_done", bus.done, 1'b1);
        tick();
        chk1("a2_idle", bus.cmd_ready, 1'b1);
        bus.ready = 1'b0;
        bus.wr_valid = 1'b0;

        // slave never answers
        accept(1'b0, 11'h020, 11'd1);
`ifdef VERSAT_INIT_TIMEOUT_EN
        k = 0;
        while (bus.valid && k < 40) begin
            k++;
            tick();
        end
        chk32("t_req_cycles", 32'(k), 32'd16);
        chk1("t_done", bus.done, 1'b1);
        chk1("t_error", bus.error, 1'b1);
        tick();
        chk1("t_error_sticky", bus.error, 1'b1);
        chk1("t_done_end", bus.done, 1'b0);
        accept(1'b0, 11'h0, 11'd0);
        chk1("t_error_clr", bus.error, 1'b0);
        tick();
`else
        lows = 0;
        repeat (110) begin
            if (!bus.valid) lows++;
            tick();
        end
        chk32("t_valid_lows", 32'(lows), 32'd0);
        chk1("t_error", bus.error, 1'b0);
        chk32("t_addr", 32'(bus.addr), 32'h020);
        bus.ready = 1'b1;
        bus.rdata = 32'h77;
        tick();
        bus.ready = 1'b0;
        chk32("t_rd_data", bus.rd_data, 32'h77);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk1("t_done", bus.done, 1'b1);
        tick();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
